// File: rtl/rsa_modexp_core.sv
// Montgomery modular exponentiation C = M^E mod P, bit-serial MonPro, left-to-right binary scan.
// Build option: define RSA_CONST_TIME_EN to run the multiply step for every exponent bit.
module rsa_modexp_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] Const,
    output logic             busy,
    output logic             eoc,
    output logic             err,
    output logic [WIDTH-1:0] C,
    output logic [2:0]       dbg_state_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] PRE_M = 3'd2;
    localparam logic [2:0] PRE_A = 3'd3;
    localparam logic [2:0] SQR   = 3'd4;
    localparam logic [2:0] MUL   = 3'd5;
    localparam logic [2:0] POST  = 3'd6;

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam int AW = WIDTH + 2;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d, e_q, e_d, m_q, m_d, k_q, k_d;
    logic [WIDTH-1:0] mbar_q, mbar_d, a_q, a_d, c_q, c_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             eoc_q, eoc_d, err_q, err_d;

    logic [WIDTH-1:0] op_a, op_b, mp_res;
    logic [AW-1:0]    p_ext, sum;
    logic             a_bit, e_bit, op_done;

    assign busy        = (state_q != IDLE);
    assign eoc         = eoc_q;
    assign err         = err_q;
    assign C           = c_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        e_d     = e_q;
        m_d     = m_q;
        k_d     = k_q;
        mbar_d  = mbar_q;
        a_d     = a_q;
        c_d     = c_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        eoc_d   = eoc_q;
        err_d   = err_q;

        // Operands come straight from the state; A is only rewritten at the end of a product.
        op_a = '0;
        op_b = '0;
        case (state_q)
            PRE_M:   begin op_a = m_q;        op_b = k_q;    end
            PRE_A:   begin op_a = WIDTH'(1);  op_b = k_q;    end
            SQR:     begin op_a = a_q;        op_b = a_q;    end
            MUL:     begin op_a = a_q;        op_b = mbar_q; end
            POST:    begin op_a = a_q;        op_b = WIDTH'(1); end
            default: begin op_a = '0;         op_b = '0;     end
        endcase

        a_bit   = |(op_a & (WIDTH'(1) << cnt_q));
        e_bit   = |(e_q & (WIDTH'(1) << idx_q));
        p_ext   = {2'b00, p_q};
        sum     = acc_q + (a_bit ? {2'b00, op_b} : '0);
        mp_res  = (acc_q >= p_ext) ? WIDTH'(acc_q - p_ext) : WIDTH'(acc_q);
        op_done = (cnt_q == CW'(WIDTH));

        case (state_q)
            IDLE: begin
                if (start) begin
                    p_d     = P;
                    e_d     = E;
                    m_d     = M;
                    k_d     = Const;
                    acc_d   = '0;
                    cnt_d   = '0;
                    eoc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Montgomery reduction needs an odd modulus greater than one.
                if (!p_q[0] || p_q == WIDTH'(1)) begin
                    err_d   = 1'b1;
                    eoc_d   = 1'b1;
                    c_d     = '0;
                    state_d = IDLE;
                end else begin
                    state_d = PRE_M;
                end
            end
            default: begin
                if (!op_done) begin
                    acc_d = (sum + (sum[0] ? p_ext : '0)) >> 1;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    acc_d = '0;
                    cnt_d = '0;
                    case (state_q)
                        PRE_M: begin
                            mbar_d  = mp_res;
                            state_d = PRE_A;
                        end
                        PRE_A: begin
                            a_d     = mp_res;
                            idx_d   = IW'(WIDTH - 1);
                            state_d = SQR;
                        end
                        SQR: begin
                            a_d = mp_res;
`ifdef RSA_CONST_TIME_EN
                            state_d = MUL;
`else
                            if (e_bit) begin
                                state_d = MUL;
                            end else if (idx_q == '0) begin
                                state_d = POST;
                            end else begin
                                idx_d   = idx_q - IW'(1);
                                state_d = SQR;
                            end
`endif
                        end
                        MUL: begin
                            if (e_bit) begin
                                a_d = mp_res;
                            end
                            if (idx_q == '0) begin
                                state_d = POST;
                            end else begin
                                idx_d   = idx_q - IW'(1);
                                state_d = SQR;
                            end
                        end
                        POST: begin
                            c_d     = mp_res;
                            eoc_d   = 1'b1;
                            state_d = IDLE;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            k_q     <= '0;
            mbar_q  <= '0;
            a_q     <= '0;
            c_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            eoc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            p_q     <= p_d;
            e_q     <= e_d;
            m_q     <= m_d;
            k_q     <= k_d;
            mbar_q  <= mbar_d;
            a_q     <= a_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            eoc_q   <= eoc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed + random bench for rsa_modexp_core: scoreboard of expected {err,C}, latency model.
module tb_rsa_modexp_core;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, en, start;
    logic [W-1:0] P, E, M, Const;
    logic         busy, eoc, err;
    logic [W-1:0] C;
    logic [2:0]   dbg_state;

    logic [W:0]   exp_q[$];
    int           n_vec;
    int           n_bad;

    rsa_modexp_core #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .P           (P),
        .E           (E),
        .M           (M),
        .Const       (Const),
        .busy        (busy),
        .eoc         (eoc),
        .err         (err),
        .C           (C),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] p, input logic [W-1:0] e,
                                           input logic [W-1:0] m);
        longint r, b;
        r = 1;
        b = longint'(m) % longint'(p);
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % longint'(p);
            if (e[i]) r = (r * b) % longint'(p);
        end
        return W'(r);
    endfunction

    function automatic int exp_latency(input logic [W-1:0] e);
        int n;
`ifdef RSA_CONST_TIME_EN
        n = 3 + 2 * W;
`else
        n = 3 + W + $countones(e);
`endif
        return 1 + n * (W + 1);
    endfunction

    function automatic logic [W-1:0] r2_mod(input logic [W-1:0] p);
        return W'((longint'(1) << (2 * W)) % longint'(p));
    endfunction

    // Caller must be at a negedge; start is driven immediately so back-to-back ops hit the eoc cycle.
    task automatic run_op(input logic [W-1:0] p, input logic [W-1:0] e, input logic [W-1:0] m,
                          input logic [W-1:0] k, input int stall_at, input int poke_at);
        logic       bad_p;
        logic [W:0] got, want;
        int         lat, cyc;
        bad_p = (p[0] == 1'b0) || (p == W'(1));
        lat   = bad_p ? 1 : exp_latency(e) + ((stall_at >= 0) ? 20 : 0);
        P = p; E = e; M = m; Const = k; start = 1'b1;
        exp_q.push_back(bad_p ? {1'b1, {W{1'b0}}} : {1'b0, model(p, e, m)});
        @(negedge clk);
        start = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_eoc_low", 32'(eoc), 32'd0);
        cyc = 0;
        while (eoc !== 1'b1 && cyc < 3000) begin
            if (cyc == stall_at) en = 1'b0;
            if (stall_at >= 0 && cyc == stall_at + 20) en = 1'b1;
            if (cyc == poke_at) begin
                start = 1'b1;
                M     = ~m;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        en    = 1'b1;
        if (cyc >= 3000) check("eoc_timeout", 32'(cyc), 32'(lat));
        want = exp_q.pop_front();
        got  = {err, C};
        check("result_C", 32'(got[W-1:0]), 32'(want[W-1:0]));
        check("result_err", 32'(got[W]), 32'(want[W]));
        check("latency", 32'(cyc), 32'(lat));
        check("done_busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] rp, re, rm;
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1; en = 1'b1; start = 1'b0;
        P = '0; E = '0; M = '0; Const = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_eoc", 32'(eoc), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_C", 32'(C), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        // start while reset is held must be ignored
        P = 8'd187; E = 8'd7; M = 8'd88; Const = 8'd86; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        check("start_in_rst_busy", 32'(busy), 32'd0);

        run_op(8'd187, 8'd7, 8'd88, 8'd86, -1, -1);
        run_op(8'd11, 8'd3, 8'd5, 8'd9, -1, -1);
        run_op(8'd11, 8'd0, 8'd5, 8'd9, -1, -1);
        run_op(8'd12, 8'd7, 8'd88, 8'd86, -1, -1);
        run_op(8'd1, 8'd7, 8'd88, 8'd0, -1, -1);
        run_op(8'd187, 8'd7, 8'd88, 8'd86, -1, -1);
        run_op(8'd11, 8'd3, 8'd5, 8'd9, -1, -1);

        // reset mid-operation aborts without touching the queue
        P = 8'd187; E = 8'd7; M = 8'd88; Const = 8'd86; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_eoc", 32'(eoc), 32'd0);
        check("abort_C", 32'(C), 32'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_abort_idle", 32'(busy), 32'd0);
        run_op(8'd187, 8'd7, 8'd88, 8'd86, -1, -1);

        // en low for 20 cycles, then a start pulse while still busy
        run_op(8'd187, 8'd7, 8'd88, 8'd86, 30, 100);

        for (int i = 0; i < 4; i++) begin
            rp = W'($urandom_range(3, 255)) | W'(1);
            re = W'($urandom_range(0, 255));
            rm = W'($urandom_range(0, 255));
            run_op(rp, re, rm, r2_mod(rp), -1, -1);
        end
        run_op(8'd255, 8'd255, 8'd254, r2_mod(8'd255), -1, -1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
